// File: rtl/tblink_rpc_cmdproc.sv
// RPC command processor: parses request frames, issues one blocking invocation
// to the BFM, captures its return value and streams the response frame back.
module tblink_rpc_cmdproc #(
  parameter int MAX_PAYLOAD = 8,
  parameter int RSP_BYTES   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_dat,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     inv_valid,
  input  logic                     inv_ready,
  output logic [7:0]               inv_method,
  output logic [7:0]               inv_call_id,
  output logic [7:0]               inv_len,
  output logic [8*MAX_PAYLOAD-1:0] inv_payload,
  input  logic                     rsp_valid,
  input  logic [8*RSP_BYTES-1:0]   rsp_data,
  output logic [7:0]               out_dat,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int FB = RSP_BYTES + 2;
  localparam int CW = $clog2(FB + 1);

  typedef enum logic [2:0] {
    H_METH, H_CALL, H_LEN, PAYLOAD, DISCARD, INVOKE, WAIT_RSP, SEND
  } state_t;

  state_t state, state_n;

  logic [7:0]                   method_q, call_q, len_q, idx_q;
  logic [MAX_PAYLOAD-1:0][7:0]  pl_q;
  logic                         too_long_q;
  logic [RSP_BYTES-1:0][7:0]    rsp_q;
  logic [CW-1:0]                cnt_q;
  logic [FB-1:0][7:0]           frame;
  logic in_fire, out_fire, last_in, last_out, rsp_take;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_in  = (idx_q == len_q - 8'd1);
  assign last_out = (cnt_q == CW'(FB - 1));
  // The return is only taken once the BFM has accepted the call.
  assign rsp_take = rsp_valid && ((state == INVOKE && inv_ready) || state == WAIT_RSP);

  always_ff @(posedge clock) begin
    if (reset) state <= H_METH;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    inv_valid = 1'b0;
    out_valid = 1'b0;
    case (state)
      H_METH: begin
        in_ready = 1'b1;
        if (in_fire) state_n = H_CALL;
      end
      H_CALL: begin
        in_ready = 1'b1;
        if (in_fire) state_n = H_LEN;
      end
      H_LEN: begin
        in_ready = 1'b1;
        if (in_fire) begin
          if (in_dat == 8'd0)                      state_n = INVOKE;
          else if (in_dat <= 8'(MAX_PAYLOAD))      state_n = PAYLOAD;
          else                                     state_n = DISCARD;
        end
      end
      PAYLOAD: begin
        in_ready = 1'b1;
        if (in_fire && last_in) state_n = INVOKE;
      end
      DISCARD: begin
        in_ready = 1'b1;
        if (in_fire && last_in) state_n = SEND;
      end
      INVOKE: begin
        inv_valid = 1'b1;
        if (inv_ready) state_n = rsp_valid ? SEND : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_valid) state_n = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_fire && last_out) state_n = H_METH;
      end
      default: state_n = H_METH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      method_q   <= '0;
      call_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      pl_q       <= '0;
      too_long_q <= 1'b0;
      rsp_q      <= '0;
      cnt_q      <= '0;
    end else begin
      // Frame start wipes everything from the previous call so unused
      // payload bytes and rejected-call data read as zero.
      if (state == H_METH && in_fire) begin
        method_q   <= in_dat;
        pl_q       <= '0;
        too_long_q <= 1'b0;
        rsp_q      <= '0;
      end
      if (state == H_CALL && in_fire) call_q <= in_dat;
      if (state == H_LEN && in_fire) begin
        len_q      <= in_dat;
        idx_q      <= '0;
        too_long_q <= (in_dat > 8'(MAX_PAYLOAD));
      end
      if ((state == PAYLOAD || state == DISCARD) && in_fire) idx_q <= idx_q + 8'd1;
      if (state == PAYLOAD && in_fire) begin
        for (int k = 0; k < MAX_PAYLOAD; k++)
          if (idx_q == 8'(k)) pl_q[k] <= in_dat;
      end
      if (rsp_take) rsp_q <= rsp_data;
      if (state_n == SEND && state != SEND) cnt_q <= '0;
      else if (out_fire)                    cnt_q <= cnt_q + CW'(1);
    end
  end

  assign inv_method  = method_q;
  assign inv_call_id = call_q;
  assign inv_len     = len_q;
  assign inv_payload = pl_q;
  assign frame       = {rsp_q, {7'd0, too_long_q}, call_q};

  always_comb begin
    out_dat = '0;
    if (state == SEND) begin
      for (int k = 0; k < FB; k++)
        if (cnt_q == CW'(k)) out_dat = frame[k];
    end
  end

endmodule

// File: tb/tb_tblink_rpc_cmdproc.sv
// Directed bench for tblink_rpc_cmdproc: frame-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_tblink_rpc_cmdproc;
  localparam int MP = 8;
  localparam int RB = 4;

  logic              clock, reset;
  logic [7:0]        in_dat;
  logic              in_valid, in_ready;
  logic              inv_valid, inv_ready;
  logic [7:0]        inv_method, inv_call_id, inv_len;
  logic [8*MP-1:0]   inv_payload;
  logic              rsp_valid;
  logic [8*RB-1:0]   rsp_data;
  logic [7:0]        out_dat;
  logic              out_valid, out_ready;

  tblink_rpc_cmdproc #(.MAX_PAYLOAD(MP), .RSP_BYTES(RB)) dut (
    .clock(clock), .reset(reset),
    .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .inv_valid(inv_valid), .inv_ready(inv_ready),
    .inv_method(inv_method), .inv_call_id(inv_call_id), .inv_len(inv_len),
    .inv_payload(inv_payload),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: frames as byte queues, the call as a pending record.
  typedef enum {M_COLLECT, M_INV, M_RSP, M_SEND} mode_t;
  mode_t        m_mode = M_COLLECT;
  logic [7:0]   fb[$];
  logic [7:0]   exp_out[$];
  logic [8*MP-1:0] exp_pl;
  bit           model_en = 0;
  bit           m_zero = 0;
  int           cyc = 0;
  int           last_acc_cyc = 0;
  int           first_out_cyc = 0;
  bit           prev_ov = 0;

  logic [7:0]   out_log[$];
  int           inv_cnt = 0;
  logic [7:0]   inv_m_log, inv_c_log, inv_l_log;
  logic [8*MP-1:0] inv_p_log;

  task automatic build_rsp(input logic [8*RB-1:0] d);
    exp_out.delete();
    exp_out.push_back(fb[1]);
    exp_out.push_back(8'h00);
    for (int b = 0; b < RB; b++) exp_out.push_back(d[8*b +: 8]);
  endtask

  always @(negedge clock) begin
    cyc++;
    if (model_en) begin
      chk("in_ready",  64'(in_ready),  64'(m_mode == M_COLLECT));
      chk("inv_valid", 64'(inv_valid), 64'(m_mode == M_INV));
      chk("out_valid", 64'(out_valid), 64'(m_mode == M_SEND));
      if (m_mode == M_INV) begin
        chk("inv_method",  64'(inv_method),  64'(fb[0]));
        chk("inv_call_id", 64'(inv_call_id), 64'(fb[1]));
        chk("inv_len",     64'(inv_len),     64'(fb[2]));
        chk("inv_payload", 64'(inv_payload), 64'(exp_pl));
      end
      if (m_mode == M_SEND && exp_out.size() > 0) chk("out_dat", 64'(out_dat), 64'(exp_out[0]));
      if (m_zero) begin
        chk("rst_out_dat",  64'(out_dat), 64'd0);
        chk("rst_inv_meth", 64'(inv_method), 64'd0);
        chk("rst_inv_call", 64'(inv_call_id), 64'd0);
        chk("rst_inv_len",  64'(inv_len), 64'd0);
        chk("rst_inv_pl",   64'(inv_payload), 64'd0);
      end
    end
    if (out_valid && !prev_ov) first_out_cyc = cyc;
    prev_ov = out_valid;
    if (!reset && out_valid && out_ready) out_log.push_back(out_dat);
    if (!reset && inv_valid && inv_ready) begin
      inv_cnt++;
      inv_m_log = inv_method; inv_c_log = inv_call_id;
      inv_l_log = inv_len;    inv_p_log = inv_payload;
    end
    // Advance the model to what the coming rising edge does.
    if (reset) begin
      m_mode = M_COLLECT; fb.delete(); exp_out.delete();
      m_zero = 1; model_en = 1;
    end else begin
      m_zero = 0;
      case (m_mode)
        M_COLLECT: if (in_valid) begin
          fb.push_back(in_dat);
          if (fb.size() >= 3 && fb.size() == 3 + int'(fb[2])) begin
            last_acc_cyc = cyc;
            if (int'(fb[2]) > MP) begin
              exp_out.delete();
              exp_out.push_back(fb[1]);
              exp_out.push_back(8'h01);
              for (int b = 0; b < RB; b++) exp_out.push_back(8'h00);
              m_mode = M_SEND;
            end else begin
              exp_pl = '0;
              for (int k = 0; k < int'(fb[2]); k++) exp_pl[8*k +: 8] = fb[3+k];
              m_mode = M_INV;
            end
          end
        end
        M_INV: if (inv_ready) begin
          if (rsp_valid) begin build_rsp(rsp_data); m_mode = M_SEND; end
          else m_mode = M_RSP;
        end
        M_RSP: if (rsp_valid) begin build_rsp(rsp_data); m_mode = M_SEND; end
        M_SEND: if (out_ready) begin
          void'(exp_out.pop_front());
          if (exp_out.size() == 0) begin m_mode = M_COLLECT; fb.delete(); end
        end
        default: m_mode = M_COLLECT;
      endcase
    end
  end

  // Stimulus helpers: inputs change only at posedge+1.
  logic [7:0] frame_q[$];
  logic [7:0] lit_q[$];

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic send_bytes(input bit rnd, input bit preset, input logic [8*RB-1:0] pdata);
    for (int i = 0; i < frame_q.size(); i++) begin
      bit fired = 0;
      int guard = 0;
      do begin
        in_dat   = frame_q[i];
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (preset && i == frame_q.size() - 1) begin
          inv_ready = 1'b1; rsp_valid = 1'b1; rsp_data = pdata;
        end
        @(negedge clock);
        fired = in_valid && in_ready;
        tick();
        guard++;
      end while (!fired && guard < 200);
      if (!fired) begin
        errors++; $display("FAIL send_timeout byte %0d", i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_invoke(input int delay, input int gap, input logic [8*RB-1:0] d);
    int g = 0;
    @(negedge clock);
    while (!inv_valid && g < 50) begin @(negedge clock); g++; end
    if (!inv_valid) begin errors++; $display("FAIL inv_timeout got 0 expected 1"); end
    tick();
    repeat (delay) tick();
    rsp_data  = d;
    inv_ready = 1'b1;
    if (gap == 0) rsp_valid = 1'b1;
    tick();
    inv_ready = 1'b0; rsp_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap - 1) tick();
      rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
    end
  endtask

  task automatic drain(input int n, input bit rnd);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      if (out_valid && out_ready) got++;
      tick();
      guard++;
    end
    out_ready = 1'b0;
    if (got < n) begin errors++; $display("FAIL drain_timeout got %0d expected %0d", got, n); end
  endtask

  task automatic chk_log(input string name, input int start);
    chk({name, "_len"}, 64'(out_log.size() - start), 64'(lit_q.size()));
    for (int i = 0; i < lit_q.size(); i++)
      if (start + i < out_log.size())
        chk(name, 64'(out_log[start + i]), 64'(lit_q[i]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; inv_ready = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("lit_rst_in_ready",  64'(in_ready),  64'd1);
    chk("lit_rst_inv_valid", 64'(inv_valid), 64'd0);
    chk("lit_rst_out_valid", 64'(out_valid), 64'd0);
    chk("lit_rst_payload",   64'(inv_payload), 64'd0);
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s, ic;
    reset = 1'b1; in_dat = '0; in_valid = 1'b0; inv_ready = 1'b0;
    rsp_valid = 1'b0; rsp_data = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    chk("lit_init_in_ready", 64'(in_ready), 64'd1);
    chk("lit_init_out_dat",  64'(out_dat),  64'd0);
    tick();

    // Basic two-byte payload, return one cycle after the handshake.
    s = out_log.size(); ic = inv_cnt;
    frame_q = {8'h05, 8'h11, 8'h02, 8'hAA, 8'hBB};
    send_bytes(0, 0, '0);
    do_invoke(0, 1, 32'h12345678);
    drain(6, 0);
    chk("lit_inv_cnt",  64'(inv_cnt - ic), 64'd1);
    chk("lit_inv_meth", 64'(inv_m_log), 64'h05);
    chk("lit_inv_call", 64'(inv_c_log), 64'h11);
    chk("lit_inv_len",  64'(inv_l_log), 64'h02);
    chk("lit_inv_pl",   64'(inv_p_log), 64'h0000_0000_0000_BBAA);
    lit_q = {8'h11, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    chk_log("lit_rsp_basic", s);

    // Zero-length with minimum turnaround.
    s = out_log.size();
    frame_q = {8'h01, 8'h22, 8'h00};
    send_bytes(0, 1, 32'hA1B2C3D4);
    tick();
    inv_ready = 1'b0; rsp_valid = 1'b0;
    drain(6, 0);
    chk("lit_turnaround", 64'(first_out_cyc - last_acc_cyc), 64'd2);
    lit_q = {8'h22, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
    chk_log("lit_rsp_zero", s);

    // Oversize payload is discarded and rejected.
    s = out_log.size(); ic = inv_cnt;
    frame_q = {8'h03, 8'h44, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
               8'h06, 8'h07, 8'h08, 8'h09};
    send_bytes(0, 0, '0);
    drain(6, 0);
    chk("lit_discard_no_inv", 64'(inv_cnt - ic), 64'd0);
    lit_q = {8'h44, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    chk_log("lit_rsp_discard", s);

    // Same call as the first one under backpressure everywhere.
    s = out_log.size();
    frame_q = {8'h05, 8'h11, 8'h02, 8'hAA, 8'hBB};
    send_bytes(1, 0, '0);
    do_invoke(10, 1, 32'h12345678);
    drain(6, 1);
    lit_q = {8'h11, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    chk_log("lit_rsp_stall", s);

    // Spurious return strobe while waiting for the length byte.
    s = out_log.size();
    frame_q = {8'h09, 8'h55};
    send_bytes(0, 0, '0);
    rsp_data = 32'hDEADBEEF; rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    frame_q = {8'h01, 8'h3C};
    send_bytes(0, 0, '0);
    do_invoke(2, 3, 32'hCAFEF00D);
    drain(6, 0);
    lit_q = {8'h55, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    chk_log("lit_rsp_spurious", s);

    // Reset mid-payload, then mid-response, then a clean call.
    frame_q = {8'h07, 8'h66, 8'h04, 8'h01, 8'h02};
    send_bytes(0, 0, '0);
    do_reset();
    frame_q = {8'h02, 8'h77, 8'h00};
    send_bytes(0, 0, '0);
    do_invoke(0, 0, 32'h11223344);
    drain(2, 0);
    do_reset();
    s = out_log.size(); ic = inv_cnt;
    frame_q = {8'h07, 8'h33, 8'h01, 8'h5A};
    send_bytes(0, 0, '0);
    do_invoke(0, 0, 32'h00000001);
    drain(6, 0);
    chk("lit_post_rst_inv", 64'(inv_cnt - ic), 64'd1);
    chk("lit_post_rst_pl",  64'(inv_p_log), 64'h0000_0000_0000_005A);
    lit_q = {8'h33, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    chk_log("lit_rsp_post_rst", s);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
